// File: rtl/nios_system_game_events.sv
// Avalon-MM input port for game-logic event strobes. The event lines are
// synchronized and their edges are latched into a sticky capture register
// that software clears by writing 1s. Unmasked captures raise a level irq.
module nios_system_game_events #(
  parameter int WIDTH     = 8,  // number of event lines, 1..32
  parameter int EDGE_TYPE = 0   // 0 = rising, 1 = falling, 2 = any
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_RSVD    = 2'd1,
    ADDR_MASK    = 2'd2,
    ADDR_CAPTURE = 2'd3
  } reg_addr_e;

  reg_addr_e        sel;
  logic [WIDTH-1:0] s1, s2, s3;
  logic [1:0]       warm_cnt;
  logic             warm_done;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] clear_bits;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             rd_en;
  logic             unused_wdata;

  assign sel       = reg_addr_e'(address);
  assign wr_en     = chipselect & ~write_n;
  assign rd_en     = chipselect & ~read_n;
  assign warm_done = (warm_cnt == 2'd3);

  // Only the low WIDTH bits of writedata reach any register.
  assign unused_wdata = ^writedata;

  // Two-flop synchronizer plus a delayed copy for edge detection, and the
  // warm-up counter that suppresses edges from lines already high at reset.
  // NOTE: every register here, including the synchronizer chain, is reset
  // so a reset mid-operation discards edges already in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1       <= '0;
      s2       <= '0;
      s3       <= '0;
      warm_cnt <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments make s1 -> s2 -> s3 a true shift
      // chain; blocking ones would collapse it into a single flop.
      s1       <= in_port;
      s2       <= s1;
      s3       <= s2;
      warm_cnt <= warm_done ? warm_cnt : warm_cnt + 2'd1;
    end
  end

  // Edge selection, gated off until the synchronizer holds real samples.
  always_comb begin
    // NOTE: assigning a default before the case keeps this purely
    // combinational; a missing path would otherwise infer a latch.
    edge_hit = '0;
    case (EDGE_TYPE)
      0:       edge_hit = s2 & ~s3;
      1:       edge_hit = ~s2 & s3;
      default: edge_hit = s2 ^ s3;
    endcase
    if (!warm_done) edge_hit = '0;
  end

  // Write-1-to-clear bits for the capture register.
  always_comb begin
    clear_bits = '0;
    if (wr_en && sel == ADDR_CAPTURE) clear_bits = writedata[WIDTH-1:0];
  end

  // Mask and sticky capture registers; a new edge beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      if (wr_en && sel == ADDR_MASK) irq_mask <= writedata[WIDTH-1:0];
      edge_capture <= (edge_capture & ~clear_bits) | edge_hit;
    end
  end

  // Read multiplexer, zero-extended to the bus width.
  always_comb begin
    rd_mux = '0;
    case (sel)
      ADDR_DATA:    rd_mux[WIDTH-1:0] = s2;
      ADDR_MASK:    rd_mux[WIDTH-1:0] = irq_mask;
      ADDR_CAPTURE: rd_mux[WIDTH-1:0] = edge_capture;
      default:      rd_mux = '0;
    endcase
  end

  // Registered read data; holds its value between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else if (rd_en) begin
      readdata <= rd_mux;
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_nios_system_game_events.sv
// Bench for nios_system_game_events: one instance per edge type shares the
// bus and event lines; a queue-based reference model predicts every output.
module tb_nios_system_game_events;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] rd_o  [3];
  logic        irq_o [3];

  int checks   = 0;
  int failures = 0;

  // Reference model state, one set per edge type (index = EDGE_TYPE).
  logic [7:0]  samples[$];   // in_port as sampled since reset, last 3 kept
  logic [7:0]  mask_m [3];
  logic [7:0]  cap_m  [3];
  logic [31:0] rd_m   [3];

  always #5 clk = ~clk;

  nios_system_game_events #(.WIDTH(8), .EDGE_TYPE(0)) u_rise (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(rd_o[0]), .in_port(in_port), .irq(irq_o[0]));

  nios_system_game_events #(.WIDTH(8), .EDGE_TYPE(1)) u_fall (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(rd_o[1]), .in_port(in_port), .irq(irq_o[1]));

  nios_system_game_events #(.WIDTH(8), .EDGE_TYPE(2)) u_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(rd_o[2]), .in_port(in_port), .irq(irq_o[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    logic [7:0] lvl, prev, ev, clr;
    int n;
    if (reset) begin
      samples.delete();
      for (int k = 0; k < 3; k++) begin
        mask_m[k] = '0;
        cap_m[k]  = '0;
        rd_m[k]   = '0;
      end
      return;
    end
    n    = samples.size();
    lvl  = (n >= 2) ? samples[n-2] : 8'h00;   // synchronized level
    prev = (n >= 3) ? samples[n-3] : 8'h00;   // level one cycle earlier
    clr  = (chipselect && !write_n && address == 2'd3) ? writedata[7:0] : 8'h00;
    for (int k = 0; k < 3; k++) begin
      if (n < 3)       ev = 8'h00;
      else if (k == 0) ev = lvl & ~prev;
      else if (k == 1) ev = ~lvl & prev;
      else             ev = lvl ^ prev;
      if (chipselect && !read_n) begin
        case (address)
          2'd0:    rd_m[k] = {24'h0, lvl};
          2'd2:    rd_m[k] = {24'h0, mask_m[k]};
          2'd3:    rd_m[k] = {24'h0, cap_m[k]};
          default: rd_m[k] = 32'h0;
        endcase
      end
      cap_m[k] = (cap_m[k] & ~clr) | ev;
      if (chipselect && !write_n && address == 2'd2) mask_m[k] = writedata[7:0];
    end
    samples.push_back(in_port);
    if (samples.size() > 3) void'(samples.pop_front());
  endtask

  // One clock: update the model at the edge, then compare just after it.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("readdata[et%0d]", k), rd_o[k], rd_m[k]);
      check($sformatf("irq[et%0d]", k), {31'h0, irq_o[k]}, {31'h0, |(cap_m[k] & mask_m[k])});
    end
  endtask

  task automatic bus_idle();
    chipselect = 1'b0;
    read_n     = 1'b1;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = 32'h0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    read_n     = 1'b1;
    address    = a;
    writedata  = d;
    tick();
    bus_idle();
  endtask

  task automatic bus_read(input logic [1:0] a);
    chipselect = 1'b1;
    read_n     = 1'b0;
    write_n    = 1'b1;
    address    = a;
    tick();
    bus_idle();
  endtask

  initial begin
    bus_idle();
    // Reset with every line high: no spurious edges after warm-up.
    reset   = 1'b1;
    in_port = 8'hFF;
    repeat (2) tick();
    reset = 1'b0;
    repeat (5) tick();
    bus_read(2'd3);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_capture[et%0d]", k), rd_o[k], 32'h0);
      check($sformatf("reset_irq[et%0d]", k), {31'h0, irq_o[k]}, 32'h0);
    end
    bus_read(2'd0);
    for (int k = 0; k < 3; k++) check($sformatf("reset_data[et%0d]", k), rd_o[k], 32'h0000_00FF);

    // Rising capture with exact latency.
    in_port = 8'h00;
    repeat (4) tick();
    bus_write(2'd3, 32'hFF);
    bus_write(2'd2, 32'h05);
    in_port = 8'h01;
    tick();
    tick();
    check("rise_irq_before_capture", {31'h0, irq_o[0]}, 32'h0);
    tick();
    check("rise_irq_at_capture", {31'h0, irq_o[0]}, 32'h1);
    tick();
    in_port = 8'h00;
    bus_read(2'd3);
    check("rise_capture", rd_o[0], 32'h1);

    // Masked capture, then clear.
    repeat (4) tick();
    bus_write(2'd3, 32'hFF);
    in_port = 8'h02;
    repeat (4) tick();
    bus_read(2'd3);
    check("masked_capture", rd_o[0], 32'h2);
    check("masked_irq", {31'h0, irq_o[0]}, 32'h0);
    bus_write(2'd3, 32'h02);
    bus_read(2'd3);
    check("cleared_capture", rd_o[0], 32'h0);

    // Partial clear keeps the other captured bit and its irq.
    in_port = 8'h83;
    repeat (4) tick();
    bus_read(2'd3);
    check("two_captures", rd_o[0], 32'h81);
    bus_write(2'd2, 32'h80);
    bus_write(2'd3, 32'h01);
    bus_read(2'd3);
    check("partial_clear", rd_o[0], 32'h80);
    check("partial_clear_irq", {31'h0, irq_o[0]}, 32'h1);

    // Clear of bit 2 in the very cycle its edge is captured.
    in_port = 8'h87;
    tick();
    tick();
    bus_write(2'd3, 32'h04);
    bus_read(2'd3);
    check("edge_beats_clear", rd_o[0], 32'h84);

    // Toggle line 3 up then down across all edge types.
    repeat (4) tick();
    bus_write(2'd3, 32'hFF);
    in_port = 8'h8F;
    repeat (4) tick();
    bus_read(2'd3);
    check("any_rise", rd_o[2], 32'h08);
    check("fall_on_rise", rd_o[1], 32'h00);
    bus_write(2'd3, 32'hFF);
    in_port = 8'h87;
    repeat (4) tick();
    bus_read(2'd3);
    check("any_fall", rd_o[2], 32'h08);
    check("fall_on_fall", rd_o[1], 32'h08);
    check("rise_on_fall", rd_o[0], 32'h00);

    // Reset with an edge in flight; it must be discarded after warm-up.
    bus_write(2'd2, 32'hFF);
    check("pre_reset_irq", {31'h0, irq_o[1]}, 32'h1);
    in_port = 8'h8F;
    tick();
    reset = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("midreset_rd[et%0d]", k), rd_o[k], 32'h0);
      check($sformatf("midreset_irq[et%0d]", k), {31'h0, irq_o[k]}, 32'h0);
    end
    reset = 1'b0;
    repeat (5) tick();
    bus_read(2'd3);
    for (int k = 0; k < 3; k++) check($sformatf("warmup_capture[et%0d]", k), rd_o[k], 32'h0);
    bus_read(2'd0);
    for (int k = 0; k < 3; k++) check($sformatf("warmup_data[et%0d]", k), rd_o[k], 32'h8F);
    bus_read(2'd2);
    for (int k = 0; k < 3; k++) check($sformatf("warmup_mask[et%0d]", k), rd_o[k], 32'h0);

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
      reset      = ($urandom_range(0, 99) == 0);
      chipselect = ($urandom_range(0, 3) != 0);
      read_n     = ($urandom_range(0, 1) == 0);
      write_n    = ($urandom_range(0, 2) == 0);
      address    = 2'($urandom);
      writedata  = $urandom;
      tick();
    end
    bus_idle();
    reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nios_system_game_events.md
# nios_system_game_events

Avalon-MM slave input port that carries game-logic event strobes (hits, pickups, door triggers) from the fabric into the Nios II processor. It is the read-direction counterpart of the system's output PIO slaves. It synchronizes a parallel input bus, latches selected edges into a sticky edge-capture register, and raises a maskable interrupt. Software reads the live level and the captured edges, then clears captures by writing 1s.

## Interface

Parameters:
- WIDTH, 8 — number of input event lines, 1..32.
- EDGE_TYPE, 0 — edge that sets a capture bit: 0 = rising, 1 = falling, 2 = any.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- address  input  2  word address of the register.
- chipselect  input  1  slave select.
- read_n  input  1  active-low read strobe.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- readdata  output  32  read data, registered; bits above WIDTH-1 are always 0.
- in_port  input  WIDTH  asynchronous event lines from game logic.
- irq  output  1  level interrupt to the CPU.

## Operation

- Synchronizer: in_port feeds s1 then s2 (two flops, metastability). s3 is the delayed copy of s2 used for edge detection. All three reset to 0.
- Edge vector:
  - rise = s2 & ~s3
  - fall = ~s2 & s3
  - edge is selected by EDGE_TYPE: rise, fall, or rise|fall.
- Warm-up: a 2-bit counter resets to 0 and saturates at 3. The edge vector is forced to 0 until the counter reaches 3. This stops a line that is high at reset from reporting a spurious edge.
- Register map (address):
  - 0 data: read returns s2. Writes are ignored.
  - 1 reserved: reads 0. Writes are ignored.
  - 2 irq_mask: WIDTH bits, read/write, reset 0. A write loads writedata[WIDTH-1:0].
  - 3 edge_capture: WIDTH bits, reset 0.
    - Set bit i when edge[i] = 1.
    - A write clears every bit i where writedata[i] = 1; bits written 0 are unchanged.
- Write qualification: chipselect & ~write_n.
- Read qualification: chipselect & ~read_n. readdata loads the selected register zero-extended. When not reading, readdata holds its last value.
- Simultaneous edge on bit i and a write-1-clear of bit i in the same cycle: the edge wins and the bit stays 1, so no event is lost.
- irq = |(edge_capture & irq_mask), driven from registers only (no combinational path from in_port).
- Reset mid-operation: every register returns to 0 on the next clock. The warm-up counter restarts, so edges present during the warm-up are discarded.

## Timing

- Reset values: readdata = 0, irq = 0, irq_mask = 0, edge_capture = 0, s1/s2/s3 = 0, warm-up counter = 0.
- Read latency is 1 cycle. readdata is valid on the clock after the read strobe is sampled. There is no wait-state; each access completes in one cycle.
- Input to capture latency, after warm-up: an in_port transition that meets setup before edge N gives:
  - s1 at N, s2 at N+1, edge_capture bit at N+2.
  - irq high after N+2 if the bit is unmasked.
- Input to data-read latency: s2 updates at N+1. A read issued in the cycle after N+1 returns the new level.
- irq_mask write: irq follows in the cycle after the write edge.
- edge_capture clear: irq deasserts in the cycle after the write edge, unless another unmasked capture bit is still set.
- Minimum detectable pulse is one full clk period of in_port. Shorter pulses may be missed.
- Back-to-back reads and writes on consecutive cycles are allowed.

## Test plan

- Reset: hold reset 2 cycles with in_port = 8'hFF, release, wait 5 cycles. Read address 3 returns 0, irq = 0, and a read of address 0 returns 32'h000000FF.
- Rising capture: EDGE_TYPE = 0, write 8'h05 to address 2, pulse in_port[0] high for 3 cycles. edge_capture = 8'h01 exactly 2 cycles after the first sampled edge, and irq = 1 from the next cycle. Read address 3 returns 32'h00000001.
- Mask and clear:
  - Set in_port[1] rising with mask 8'h05. Capture reads 8'h02 and irq stays 0.
  - Write 8'h02 to address 3. Capture reads 0.
- Partial clear: captures = 8'h81. Write 8'h01 to address 3; read returns 8'h80 and irq stays high if mask bit 7 is set.
- Simultaneous set/clear: schedule a clear-write of bit 2 in the same cycle that edge[2] is asserted. Capture bit 2 reads 1 afterwards.
- EDGE_TYPE = 2 and 1: toggle in_port[3] 0→1→0 with clears between steps.
  - EDGE_TYPE = 2: two separate captures.
  - EDGE_TYPE = 1: only the 1→0 transition captures.
  - Apply reset mid-sequence: all registers read 0 and irq drops on the next clock.
